// File: rtl/zyy_seg_pkg.sv
// Shared types and constants for the game timer / seven-segment scan block.
package zyy_seg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam bcd_t       BLANK   = 4'hF;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Active-low {g,f,e,d,c,b,a}; index is the BCD value.
    localparam logic [9:0][6:0] SEG_LUT = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    function automatic logic [6:0] seg_decode(input bcd_t d);
        if (d < 4'd10) return SEG_LUT[d];
        return SEG_OFF;
    endfunction

    // mm:ss stored as {mm tens, mm units, ss tens, ss units}.
    function automatic logic [3:0][3:0] tm_inc(input logic [3:0][3:0] t);
        logic [3:0][3:0] r;
        r = t;
        if (t[0] != 4'd9) r[0] = t[0] + 4'd1;
        else begin
            r[0] = 4'd0;
            if (t[1] != 4'd5) r[1] = t[1] + 4'd1;
            else begin
                r[1] = 4'd0;
                if (t[2] != 4'd9) r[2] = t[2] + 4'd1;
                else begin
                    r[2] = 4'd0;
                    r[3] = t[3] + 4'd1;
                end
            end
        end
        return r;
    endfunction

    function automatic logic [3:0][3:0] tm_dec(input logic [3:0][3:0] t);
        logic [3:0][3:0] r;
        r = t;
        if (t[0] != 4'd0) r[0] = t[0] - 4'd1;
        else begin
            r[0] = 4'd9;
            if (t[1] != 4'd0) r[1] = t[1] - 4'd1;
            else begin
                r[1] = 4'd5;
                if (t[2] != 4'd0) r[2] = t[2] - 4'd1;
                else begin
                    r[2] = 4'd9;
                    r[3] = t[3] - 4'd1;
                end
            end
        end
        return r;
    endfunction

    // Four-digit BCD increment that sticks at 9999.
    function automatic logic [3:0][3:0] score_inc(input logic [3:0][3:0] s);
        logic [3:0][3:0] r;
        logic            carry;
        r     = s;
        carry = 1'b1;
        if (s == 16'h9999) return s;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (s[i] == 4'd9) r[i] = 4'd0;
                else begin
                    r[i]  = s[i] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/zyy_seg_scan.sv
// Seven-segment scanner: steps through the digit bus at SCAN_DIV cycles per
// digit and drives registered, mutually consistent segment / enable outputs.
module zyy_seg_scan
    import zyy_seg_pkg::*;
#(
    parameter int DIGITS   = 8,
    parameter int SCAN_DIV = 100000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DIGITS-1:0][3:0] digits_i,
    output logic [6:0]             seg_o,
    output logic [DIGITS-1:0]      law_o
);

    localparam int DW = $clog2(SCAN_DIV + 1);
    localparam int IW = $clog2(DIGITS);

    logic [DW-1:0]     div_q;
    logic [IW-1:0]     idx_q, sel_q;
    logic              stb_q;
    logic [6:0]        seg_q, seg_d;
    logic [DIGITS-1:0] law_q, law_d;
    logic              wrap;

    assign wrap = (div_q == DW'(SCAN_DIV - 1));

    // Segment pattern and enable for the digit captured at the last wrap.
    always_comb begin
        seg_d = seg_decode(digits_i[sel_q]);
        law_d = ~(DIGITS'(1) << sel_q);
    end

    // Divider/index advance on wrap; outputs load together one cycle later.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_q <= '0;
            idx_q <= '0;
            sel_q <= '0;
            stb_q <= 1'b0;
            seg_q <= SEG_OFF;
            law_q <= '1;
        end else begin
            stb_q <= wrap;
            if (wrap) begin
                div_q <= '0;
                sel_q <= idx_q;
                idx_q <= (idx_q == IW'(DIGITS - 1)) ? '0 : idx_q + 1'b1;
            end else begin
                div_q <= div_q + 1'b1;
            end
            if (stb_q) begin
                seg_q <= seg_d;
                law_q <= law_d;
            end
        end
    end

    assign seg_o = seg_q;
    assign law_o = law_q;

endmodule

// File: rtl/zyy_seg_timer.sv
// Game timer (count up / count down), BCD hit score and display driver.
module zyy_seg_timer
    import zyy_seg_pkg::*;
#(
    parameter int DIGITS     = 8,
    parameter int SCAN_DIV   = 100000,
    parameter int SEC_DIV    = 100000000,
    parameter int PRESET_MIN = 2,
    parameter int PRESET_SEC = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic              over,
    input  logic              mode,
    input  logic              hit,
    output logic              running,
    output logic              timeout,
    output logic [6:0]        oData,
    output logic [DIGITS-1:0] law
);

    localparam int SW = $clog2(SEC_DIV + 1);
    localparam logic [3:0][3:0] PRESET_TM = {
        4'(PRESET_MIN / 10), 4'(PRESET_MIN % 10),
        4'(PRESET_SEC / 10), 4'(PRESET_SEC % 10)
    };

    state_e          state_q, state_d;
    logic            mode_q, mode_d;
    logic [SW-1:0]   sdiv_q, sdiv_d;
    logic [3:0][3:0] tm_q, tm_d, tm_load;
    logic [3:0][3:0] score_q, score_d;
    logic            tmo_q, tmo_d;
    logic            run_q;
    logic            sec_wrap;
    logic [7:0][3:0] dig_all;

    assign sec_wrap = (sdiv_q == SW'(SEC_DIV - 1));
    assign tm_load  = mode ? PRESET_TM : '0;

    // Next state: start low, over, terminal time, pause, second tick.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        sdiv_d  = sdiv_q;
        tm_d    = tm_q;
        score_d = score_q;
        tmo_d   = tmo_q;
        if (!start) begin
            state_d = ST_IDLE;
            score_d = '0;
            tmo_d   = 1'b0;
            tm_d    = tm_load;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mode_d  = mode;
                    tm_d    = tm_load;
                    sdiv_d  = '0;
                    state_d = over ? ST_DONE : ST_RUN;
                end
                ST_RUN: begin
                    if (hit) score_d = score_inc(score_q);
                    if (over) begin
                        state_d = ST_DONE;
                    end else if (mode_q && tm_q == '0) begin
                        tmo_d   = 1'b1;
                        state_d = ST_DONE;
                    end else if (pause) begin
                        state_d = ST_PAUSE;
                    end else if (sec_wrap) begin
                        sdiv_d = '0;
                        if (!mode_q) begin
                            if (tm_q == 16'h9959) state_d = ST_DONE;
                            else                  tm_d    = tm_inc(tm_q);
                        end else begin
                            tm_d = tm_dec(tm_q);
                            if (tm_d == '0) begin
                                tmo_d   = 1'b1;
                                state_d = ST_DONE;
                            end
                        end
                    end else begin
                        sdiv_d = sdiv_q + 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (over)        state_d = ST_DONE;
                    else if (!pause) state_d = ST_RUN;
                end
                default: ;
            endcase
        end
    end

    // Timer, score and FSM registers; running is registered from next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            mode_q  <= 1'b0;
            sdiv_q  <= '0;
            tm_q    <= '0;
            score_q <= '0;
            tmo_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            sdiv_q  <= sdiv_d;
            tm_q    <= tm_d;
            score_q <= score_d;
            tmo_q   <= tmo_d;
            run_q   <= (state_d == ST_RUN);
        end
    end

    assign running = run_q;
    assign timeout = tmo_q;
    assign dig_all = {score_q, tm_q};

    zyy_seg_scan #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) u_scan (
        .clk      (clk),
        .rst      (rst),
        .digits_i (dig_all[DIGITS-1:0]),
        .seg_o    (oData),
        .law_o    (law)
    );

endmodule
